// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store unit between the pipeline and a single-port data memory.
//
// One request is handled at a time through IDLE -> ACCESS -> RESP:
//   IDLE   : request accepted and registered, fault decoded.
//   ACCESS : dmem_* driven for exactly one cycle; load data formatted and
//            captured.
//   RESP   : response held stable until resp_ready.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_we, req_funct3              store flag, RV32I width/sign code
//   req_addr, req_wdata             byte address, right-justified store data
//   resp_valid/resp_ready           response handshake
//   resp_rdata, resp_fault          formatted load data, fault flag
//   dmem_addr, dmem_wdata           memory address and lane-replicated data
//   dmem_byte_en                    byte lanes relative to dmem_addr
//   dmem_wr_en, dmem_rd_en          single-cycle strobes
//   dmem_rdata                      combinational read data at dmem_addr
//
// Configuration
//   LSU_MISALIGN_TRAP_EN  defined  : misaligned H/W requests fault.
//                         undefined: misaligned H/W go to memory unaligned
//                                    (dmem_addr = req_addr, lane 0 data).
// -----------------------------------------------------------------------------
module lsu #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_fault,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_byte_en,
   output logic            dmem_wr_en,
   output logic            dmem_rd_en,
   input  logic [XLEN-1:0] dmem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t          state_q, state_d;
   logic            we_q, we_d;
   logic [2:0]      f3_q, f3_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic            fault_q, fault_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            rfault_q, rfault_d;

   logic            req_fault;
   logic            passthru;
   logic [4:0]      lane_sh;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] load_data;

   function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
      if (we)
         return f3[2] || (f3[1:0] == 2'b11);
      else
         return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      return ((f3[1:0] == 2'b01) && off[0]) ||
             ((f3[1:0] == 2'b10) && (off != 2'b00));
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   assign req_fault = illegal_f3(req_we, req_funct3) ||
                      misaligned(req_funct3, req_addr[1:0]);
   assign passthru  = 1'b0;
`else
   assign req_fault = illegal_f3(req_we, req_funct3);
   // Only legal requests reach memory, so misaligned() on the registered
   // request is enough to select the unaligned path.
   assign passthru  = misaligned(f3_q, addr_q[1:0]);
`endif

   // Load lane selection and sign/zero extension.
   assign lane_sh = passthru ? 5'd0 : {addr_q[1:0], 3'b000};
   assign shifted = dmem_rdata >> lane_sh;

   always_comb begin
      load_data = shifted;
      case (f3_q)
         3'b000:  load_data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
         3'b100:  load_data = {{(XLEN-8){1'b0}},         shifted[7:0]};
         3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         3'b101:  load_data = {{(XLEN-16){1'b0}},        shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid)  state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers
   always_comb begin
      we_d     = we_q;
      f3_d     = f3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      fault_d  = fault_q;
      rdata_d  = rdata_q;
      rfault_d = rfault_q;
      if (state_q == IDLE && req_valid) begin
         we_d    = req_we;
         f3_d    = req_funct3;
         addr_d  = req_addr;
         wdata_d = req_wdata;
         fault_d = req_fault;
      end
      if (state_q == ACCESS) begin
         rdata_d  = (fault_q || we_q) ? '0 : load_data;
         rfault_d = fault_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         we_q     <= 1'b0;
         f3_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         fault_q  <= 1'b0;
         rdata_q  <= '0;
         rfault_q <= 1'b0;
      end else begin
         we_q     <= we_d;
         f3_q     <= f3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         fault_q  <= fault_d;
         rdata_q  <= rdata_d;
         rfault_q <= rfault_d;
      end
   end

   // Output logic
   always_comb begin
      req_ready    = (state_q == IDLE);
      resp_valid   = (state_q == RESP);
      resp_rdata   = rdata_q;
      resp_fault   = rfault_q;
      dmem_addr    = '0;
      dmem_wdata   = '0;
      dmem_byte_en = '0;
      dmem_wr_en   = 1'b0;
      dmem_rd_en   = 1'b0;
      if (state_q == ACCESS) begin
         dmem_addr = passthru ? addr_q : {addr_q[XLEN-1:2], 2'b00};
         case (f3_q[1:0])
            2'b00: begin
               dmem_byte_en = 4'b0001 << addr_q[1:0];
               dmem_wdata   = {(XLEN/8){wdata_q[7:0]}};
            end
            2'b01: begin
               dmem_byte_en = passthru ? 4'b0011 : (4'b0011 << addr_q[1:0]);
               dmem_wdata   = {(XLEN/16){wdata_q[15:0]}};
            end
            default: begin
               dmem_byte_en = 4'b1111;
               dmem_wdata   = wdata_q;
            end
         endcase
         dmem_wr_en = !fault_q &&  we_q;
         dmem_rd_en = !fault_q && !we_q;
      end
      // Reset overrides the ACCESS cycle so an interrupted store never commits.
      if (reset) begin
         dmem_addr    = '0;
         dmem_wdata   = '0;
         dmem_byte_en = '0;
         dmem_wr_en   = 1'b0;
         dmem_rd_en   = 1'b0;
      end
   end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            req_valid, req_ready, req_we;
   logic [2:0]      req_funct3;
   logic [XLEN-1:0] req_addr, req_wdata;
   logic            resp_valid, resp_ready, resp_fault;
   logic [XLEN-1:0] resp_rdata;
   logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]      dmem_byte_en;
   logic            dmem_wr_en, dmem_rd_en;

   int n_checks = 0;
   int n_fail   = 0;

   // Byte-addressed memory model, 512 bytes, wraps on address bits [8:0].
   logic [7:0] mem [0:511];
   logic [8:0] ma;
   assign ma = dmem_addr[8:0];
   assign dmem_rdata = {mem[ma + 9'd3], mem[ma + 9'd2], mem[ma + 9'd1], mem[ma]};

   always @(posedge clk) begin
      if (dmem_wr_en)
         for (int i = 0; i < 4; i++)
            if (dmem_byte_en[i]) mem[ma + 9'(i)] <= dmem_wdata[8*i +: 8];
   end

   always #5 clk = ~clk;

   lsu #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en),
      .dmem_wr_en(dmem_wr_en), .dmem_rd_en(dmem_rd_en), .dmem_rdata(dmem_rdata)
   );

   // Observations captured by run_txn at fixed cycle offsets.
   logic        ob_idle_ready;
   logic [31:0] ob_idle_daddr;
   logic        ob_rd, ob_wr, ob_acc_rvalid;
   logic [3:0]  ob_be;
   logic [31:0] ob_addr, ob_wdata;
   logic        ob_rsp_valid, ob_rsp_fault, ob_rsp_ready;
   logic [31:0] ob_rsp_rdata;

   function automatic logic [31:0] memw(input int a);
      return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
   endfunction

   // Entered and left at a negedge with the DUT idle. Accept in N, access in
   // N+1, response in N+2, consumed immediately.
   task automatic run_txn(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      #1;
      ob_idle_ready = req_ready;
      ob_idle_daddr = dmem_addr;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      #1;
      ob_rd = dmem_rd_en; ob_wr = dmem_wr_en; ob_be = dmem_byte_en;
      ob_addr = dmem_addr; ob_wdata = dmem_wdata; ob_acc_rvalid = resp_valid;
      @(posedge clk); @(negedge clk);
      ob_rsp_valid = resp_valid; ob_rsp_rdata = resp_rdata;
      ob_rsp_fault = resp_fault; ob_rsp_ready = req_ready;
      resp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (dmem_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b exp 0", dmem_wr_en); end
      n_checks++; if (dmem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b exp 0", dmem_rd_en); end
      reset = 1'b0;
      @(posedge clk); @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b exp 1", req_ready); end
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid); end
      n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_resp_rdata: got %h exp 0", resp_rdata); end
      n_checks++; if (resp_fault !== 1'b0) begin n_fail++; $display("FAIL rst_resp_fault: got %b exp 0", resp_fault); end
      n_checks++; if ({dmem_addr, dmem_wdata, dmem_byte_en, dmem_wr_en, dmem_rd_en} !== '0) begin
         n_fail++; $display("FAIL rst_dmem: got addr %h wdata %h be %b wr %b rd %b exp all 0",
                            dmem_addr, dmem_wdata, dmem_byte_en, dmem_wr_en, dmem_rd_en); end
   endtask

   task automatic test_word();
      run_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
      n_checks++; if (ob_idle_ready !== 1'b1) begin n_fail++; $display("FAIL sw_ready: got %b exp 1", ob_idle_ready); end
      n_checks++; if (ob_idle_daddr !== 32'h0) begin n_fail++; $display("FAIL sw_idle_addr: got %h exp 0", ob_idle_daddr); end
      n_checks++; if ({ob_wr, ob_rd} !== 2'b10) begin n_fail++; $display("FAIL sw_strobes: got wr/rd %b%b exp 10", ob_wr, ob_rd); end
      n_checks++; if (ob_be !== 4'b1111) begin n_fail++; $display("FAIL sw_be: got %b exp 1111", ob_be); end
      n_checks++; if (ob_addr !== 32'h100) begin n_fail++; $display("FAIL sw_addr: got %h exp 100", ob_addr); end
      n_checks++; if (ob_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata: got %h exp deadbeef", ob_wdata); end
      n_checks++; if (ob_acc_rvalid !== 1'b0) begin n_fail++; $display("FAIL sw_early_resp: got %b exp 0", ob_acc_rvalid); end
      n_checks++; if ({ob_rsp_valid, ob_rsp_fault, ob_rsp_ready} !== 3'b100) begin
         n_fail++; $display("FAIL sw_resp: got valid/fault/ready %b%b%b exp 100", ob_rsp_valid, ob_rsp_fault, ob_rsp_ready); end
      n_checks++; if (ob_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL sw_rdata: got %h exp 0", ob_rsp_rdata); end
      n_checks++; if (memw(32'h100) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_mem: got %h exp deadbeef", memw(32'h100)); end
      run_txn(1'b0, 3'b010, 32'h100, 32'h0);
      n_checks++; if ({ob_wr, ob_rd} !== 2'b01) begin n_fail++; $display("FAIL lw_strobes: got wr/rd %b%b exp 01", ob_wr, ob_rd); end
      n_checks++; if (ob_be !== 4'b1111) begin n_fail++; $display("FAIL lw_be: got %b exp 1111", ob_be); end
      n_checks++; if (ob_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL lw_valid: got %b exp 1", ob_rsp_valid); end
      n_checks++; if (ob_rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata: got %h exp deadbeef", ob_rsp_rdata); end
   endtask

   task automatic test_byte();
      run_txn(1'b1, 3'b000, 32'h103, 32'h000000A5);
      n_checks++; if (ob_addr !== 32'h100) begin n_fail++; $display("FAIL sb_addr: got %h exp 100", ob_addr); end
      n_checks++; if (ob_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b exp 1000", ob_be); end
      n_checks++; if (ob_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h exp a5a5a5a5", ob_wdata); end
      n_checks++; if (memw(32'h100) !== 32'hA5ADBEEF) begin n_fail++; $display("FAIL sb_mem: got %h exp a5adbeef", memw(32'h100)); end
      run_txn(1'b0, 3'b000, 32'h103, 32'h0);
      n_checks++; if (ob_rsp_rdata !== 32'hFFFFFFA5) begin n_fail++; $display("FAIL lb_rdata: got %h exp ffffffa5", ob_rsp_rdata); end
      run_txn(1'b0, 3'b100, 32'h103, 32'h0);
      n_checks++; if (ob_rsp_rdata !== 32'h000000A5) begin n_fail++; $display("FAIL lbu_rdata: got %h exp 000000a5", ob_rsp_rdata); end
      run_txn(1'b0, 3'b000, 32'h101, 32'h0);
      n_checks++; if (ob_be !== 4'b0010) begin n_fail++; $display("FAIL lb1_be: got %b exp 0010", ob_be); end
      n_checks++; if (ob_rsp_rdata !== 32'hFFFFFFBE) begin n_fail++; $display("FAIL lb1_rdata: got %h exp ffffffbe", ob_rsp_rdata); end
   endtask

   task automatic test_half();
      run_txn(1'b1, 3'b010, 32'h100, 32'h80010000);
      run_txn(1'b0, 3'b001, 32'h102, 32'h0);
      n_checks++; if (ob_be !== 4'b1100) begin n_fail++; $display("FAIL lh_be: got %b exp 1100", ob_be); end
      n_checks++; if (ob_addr !== 32'h100) begin n_fail++; $display("FAIL lh_addr: got %h exp 100", ob_addr); end
      n_checks++; if (ob_rsp_rdata !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_rdata: got %h exp ffff8001", ob_rsp_rdata); end
      run_txn(1'b0, 3'b101, 32'h102, 32'h0);
      n_checks++; if (ob_rsp_rdata !== 32'h00008001) begin n_fail++; $display("FAIL lhu_rdata: got %h exp 00008001", ob_rsp_rdata); end
      run_txn(1'b1, 3'b001, 32'h100, 32'hFFFF7FFE);
      n_checks++; if (ob_be !== 4'b0011) begin n_fail++; $display("FAIL sh_be: got %b exp 0011", ob_be); end
      n_checks++; if (ob_wdata !== 32'h7FFE7FFE) begin n_fail++; $display("FAIL sh_wdata: got %h exp 7ffe7ffe", ob_wdata); end
      n_checks++; if (memw(32'h100) !== 32'h80017FFE) begin n_fail++; $display("FAIL sh_mem: got %h exp 80017ffe", memw(32'h100)); end
      run_txn(1'b0, 3'b001, 32'h100, 32'h0);
      n_checks++; if (ob_rsp_rdata !== 32'h00007FFE) begin n_fail++; $display("FAIL lh0_rdata: got %h exp 00007ffe", ob_rsp_rdata); end
   endtask

   task automatic test_illegal();
      run_txn(1'b0, 3'b011, 32'h100, 32'h0);
      n_checks++; if ({ob_wr, ob_rd} !== 2'b00) begin n_fail++; $display("FAIL ill_ld_strobes: got wr/rd %b%b exp 00", ob_wr, ob_rd); end
      n_checks++; if ({ob_rsp_valid, ob_rsp_fault} !== 2'b11) begin n_fail++; $display("FAIL ill_ld_fault: got valid/fault %b%b exp 11", ob_rsp_valid, ob_rsp_fault); end
      n_checks++; if (ob_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL ill_ld_rdata: got %h exp 0", ob_rsp_rdata); end
      run_txn(1'b0, 3'b110, 32'h100, 32'h0);
      n_checks++; if (ob_rsp_fault !== 1'b1) begin n_fail++; $display("FAIL ill_ld110_fault: got %b exp 1", ob_rsp_fault); end
      run_txn(1'b1, 3'b100, 32'h100, 32'h12345678);
      n_checks++; if ({ob_wr, ob_rsp_fault} !== 2'b01) begin n_fail++; $display("FAIL ill_st100: got wr/fault %b%b exp 01", ob_wr, ob_rsp_fault); end
      run_txn(1'b1, 3'b011, 32'h100, 32'h12345678);
      n_checks++; if ({ob_wr, ob_rsp_fault} !== 2'b01) begin n_fail++; $display("FAIL ill_st011: got wr/fault %b%b exp 01", ob_wr, ob_rsp_fault); end
      n_checks++; if (memw(32'h100) !== 32'h80017FFE) begin n_fail++; $display("FAIL ill_mem: got %h exp 80017ffe", memw(32'h100)); end
   endtask

   task automatic test_misalign();
      run_txn(1'b1, 3'b010, 32'h100, 32'h44332211);
      run_txn(1'b1, 3'b010, 32'h104, 32'h88776655);
      run_txn(1'b0, 3'b010, 32'h101, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      n_checks++; if ({ob_wr, ob_rd} !== 2'b00) begin n_fail++; $display("FAIL mis_lw_strobes: got wr/rd %b%b exp 00", ob_wr, ob_rd); end
      n_checks++; if ({ob_rsp_fault, ob_rsp_rdata} !== {1'b1, 32'h0}) begin
         n_fail++; $display("FAIL mis_lw_resp: got fault %b rdata %h exp 1 0", ob_rsp_fault, ob_rsp_rdata); end
      run_txn(1'b0, 3'b001, 32'h103, 32'h0);
      n_checks++; if ({ob_rd, ob_rsp_fault} !== 2'b01) begin n_fail++; $display("FAIL mis_lh: got rd/fault %b%b exp 01", ob_rd, ob_rsp_fault); end
      run_txn(1'b1, 3'b001, 32'h101, 32'h0000BEEF);
      n_checks++; if ({ob_wr, ob_rsp_fault} !== 2'b01) begin n_fail++; $display("FAIL mis_sh: got wr/fault %b%b exp 01", ob_wr, ob_rsp_fault); end
      n_checks++; if (memw(32'h100) !== 32'h44332211) begin n_fail++; $display("FAIL mis_sh_mem: got %h exp 44332211", memw(32'h100)); end
`else
      n_checks++; if (ob_addr !== 32'h101) begin n_fail++; $display("FAIL mis_lw_addr: got %h exp 101", ob_addr); end
      n_checks++; if ({ob_rd, ob_be} !== 5'b1_1111) begin n_fail++; $display("FAIL mis_lw_rd_be: got rd %b be %b exp 1 1111", ob_rd, ob_be); end
      n_checks++; if ({ob_rsp_fault, ob_rsp_rdata} !== {1'b0, 32'h55443322}) begin
         n_fail++; $display("FAIL mis_lw_resp: got fault %b rdata %h exp 0 55443322", ob_rsp_fault, ob_rsp_rdata); end
      run_txn(1'b0, 3'b001, 32'h103, 32'h0);
      n_checks++; if ({ob_addr, ob_be} !== {32'h103, 4'b0011}) begin n_fail++; $display("FAIL mis_lh_addr_be: got %h %b exp 103 0011", ob_addr, ob_be); end
      n_checks++; if (ob_rsp_rdata !== 32'h00005544) begin n_fail++; $display("FAIL mis_lh_rdata: got %h exp 00005544", ob_rsp_rdata); end
      run_txn(1'b1, 3'b001, 32'h101, 32'h0000BEEF);
      n_checks++; if ({ob_wr, ob_addr, ob_be} !== {1'b1, 32'h101, 4'b0011}) begin
         n_fail++; $display("FAIL mis_sh_acc: got wr %b addr %h be %b exp 1 101 0011", ob_wr, ob_addr, ob_be); end
      n_checks++; if (memw(32'h100) !== 32'h44BEEF11) begin n_fail++; $display("FAIL mis_sh_mem: got %h exp 44beef11", memw(32'h100)); end
`endif
   endtask

   task automatic test_backpressure();
      logic [31:0] held;
      run_txn(1'b1, 3'b010, 32'h100, 32'h0BADF00D);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = '0;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      held = resp_rdata;
      for (int c = 0; c < 5; c++) begin
         n_checks++; if ({resp_valid, req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL bp_hold%0d: got valid/ready %b%b exp 10", c, resp_valid, req_ready); end
         n_checks++; if (resp_rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL bp_rdata%0d: got %h exp 0badf00d", c, resp_rdata); end
         @(posedge clk); @(negedge clk);
      end
      resp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      resp_ready = 1'b0;
      n_checks++; if ({req_ready, resp_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_release: got ready/valid %b%b exp 10", req_ready, resp_valid); end
      run_txn(1'b0, 3'b100, 32'h100, 32'h0);
      n_checks++; if (ob_idle_ready !== 1'b1) begin n_fail++; $display("FAIL bp_next_accept: got %b exp 1", ob_idle_ready); end
      n_checks++; if (ob_rsp_rdata !== 32'h0000000D) begin n_fail++; $display("FAIL bp_next_rdata: got %h exp 0000000d", ob_rsp_rdata); end
   endtask

   task automatic test_reset_abort();
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'hCAFEF00D;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      #1;
      n_checks++; if (dmem_wr_en !== 1'b1) begin n_fail++; $display("FAIL ab_access_wr: got %b exp 1", dmem_wr_en); end
      reset = 1'b1;
      #1;
      n_checks++; if (dmem_wr_en !== 1'b0) begin n_fail++; $display("FAIL ab_wr_gated: got %b exp 0", dmem_wr_en); end
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++; if ({req_ready, resp_valid, resp_fault} !== 3'b100) begin
         n_fail++; $display("FAIL ab_ctrl: got ready/valid/fault %b%b%b exp 100", req_ready, resp_valid, resp_fault); end
      n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL ab_rdata: got %h exp 0", resp_rdata); end
      n_checks++; if ({dmem_addr, dmem_wdata, dmem_byte_en, dmem_wr_en, dmem_rd_en} !== '0) begin
         n_fail++; $display("FAIL ab_dmem: got addr %h wdata %h be %b exp all 0", dmem_addr, dmem_wdata, dmem_byte_en); end
      n_checks++; if (memw(32'h100) !== 32'h0BADF00D) begin n_fail++; $display("FAIL ab_mem: got %h exp 0badf00d", memw(32'h100)); end
      @(posedge clk); @(negedge clk);
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL ab_no_resp: got %b exp 0", resp_valid); end
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_illegal();
      test_misalign();
      test_backpressure();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: XLEN, default riscv_pkg XLEN (32), data/address width.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  pipeline presents a load/store request.
REQ-005 req_ready  output  1  LSU can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  XLEN  byte address.
REQ-009 req_wdata  input  XLEN  store data, right-justified.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  consumer accepts response.
REQ-012 resp_rdata  output  XLEN  formatted load result; 0 for stores and faults.
REQ-013 resp_fault  output  1  misaligned or illegal-funct3 request.
REQ-014 dmem_addr, dmem_wdata  output  XLEN  to memory controller.
REQ-015 dmem_byte_en  output  4  byte lanes relative to dmem_addr.
REQ-016 dmem_wr_en, dmem_rd_en  output  1  single-cycle strobes.
REQ-017 dmem_rdata  input  XLEN  combinational read data, 4 bytes from dmem_addr.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS, RESP; req_ready = (state == IDLE).
REQ-019 IDLE: on req_valid && req_ready, register we/funct3/addr/wdata, decode fault, go ACCESS; otherwise stay.
REQ-020 ACCESS: drive dmem_* from registered request for exactly one cycle; strobes asserted only if no fault; capture formatted load data into resp_rdata; go RESP.
REQ-021 RESP: resp_valid = 1, held with resp_rdata/resp_fault stable until resp_ready; on resp_ready go IDLE.
REQ-022 Latency: accept in cycle N -> strobe in N+1 -> resp_valid in N+2; min 3 cycles per request; no overlap.
REQ-023 Aligned mode: dmem_addr = {addr[XLEN-1:2], 2'b00}; byte_en = 0001<<addr[1:0] (B), 0011<<addr[1:0] (H), 1111 (W); dmem_wdata = store data replicated to lanes (B: 4x byte, H: 2x half, W: as-is).
REQ-024 Load format: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-025 Illegal funct3 (loads 011/110/111; stores 1xx/011) SHALL fault.
REQ-026 Faulted request: no dmem strobe, resp_rdata = 0, resp_fault = 1.
REQ-027 dmem_rd_en/dmem_wr_en SHALL be forced 0 in any cycle where reset is high.
REQ-028 dmem_addr/wdata/byte_en SHALL be 0 outside ACCESS.

Reset
REQ-029 On reset: state IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_fault = 0, all dmem_* outputs 0.
REQ-030 Reset in ACCESS or RESP SHALL abort the request with no write committed and no response issued.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 SHALL fault (REQ-026), aligned mode only.
REQ-032 Macro undefined: misaligned H/W SHALL pass through with dmem_addr = req_addr, byte_en 0011/1111, wdata unshifted, load data from lane 0; aligned accesses unchanged (REQ-023); illegal funct3 still faults.

Verification
REQ-033 SW addr 0x100 data 0xDEADBEEF, then LW 0x100 -> byte_en 1111 strobe in N+1, load resp_rdata 0xDEADBEEF in N+2.
REQ-034 SB 0x103 data 0x000000A5 -> dmem_addr 0x100, byte_en 1000, wdata 0xA5A5A5A5; LB 0x103 -> 0xFFFFFFA5, LBU -> 0x000000A5.
REQ-035 LH 0x102 with mem word 0x80010000 -> 0xFFFF8001; LHU -> 0x00008001.
REQ-036 LW 0x101: with LSU_MISALIGN_TRAP_EN -> resp_fault 1, rdata 0, no strobe; without -> dmem_addr 0x101, rd_en 1, no fault.
REQ-037 Hold resp_ready low 5 cycles -> resp_valid/rdata stable, req_ready 0; release -> IDLE next cycle, new request accepted.
REQ-038 Assert reset during ACCESS of SW -> dmem_wr_en 0, memory unchanged, next cycle all outputs at reset values.
